data_mem_arbiter: RTL and testbench

- Shares one external data-memory port among NUM_CONSUMERS per-thread load/store requesters; the requesters are the LSUs of all threads across all compute cores.
- Round-robin arbitration, one transaction in flight at a time.
- Uses the same valid/ready request-hold handshake as the LSUs on both sides.
- Sits between the compute cores and the data memory model at GPU top level.

---
 rtl/data_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among per-thread LSUs.
// One transaction in flight; valid/ready request-hold handshake on both sides.
module data_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready,
  output logic                                     busy
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_e;

  state_e                                  state_q, state_d;
  logic [PTR_W-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                        granted_q, granted_d;
  logic                                    mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]                    mem_read_address_q, mem_read_address_d;
  logic                                    mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]                    mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]                    mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]                read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
  logic [NUM_CONSUMERS-1:0]                write_ready_q, write_ready_d;
  logic                                    busy_q, busy_d;

  logic                                    pick_found;
  logic [PTR_W-1:0]                        pick_idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_CONSUMERS - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping around the consumer ring.
  always_comb begin
    logic [PTR_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!pick_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    granted_d           = granted_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    read_data_d         = read_data_q;
    write_ready_d       = write_ready_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          granted_d = pick_idx;
          // Read wins when a consumer asserts both; its write gets a later grant.
          if (consumer_read_valid[pick_idx]) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_address[pick_idx];
            state_d            = READ_WAIT;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_address[pick_idx];
            mem_write_data_d    = consumer_write_data[pick_idx];
            state_d             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d         = 1'b0;
          read_data_d[granted_q]   = mem_read_data;
          read_ready_d[granted_q]  = 1'b1;
          state_d                  = READ_RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d        = 1'b0;
          write_ready_d[granted_q] = 1'b1;
          state_d                  = WRITE_RELAY;
        end
      end
      READ_RELAY: begin
        if (!consumer_read_valid[granted_q]) begin
          read_ready_d[granted_q] = 1'b0;
          rr_ptr_d                = wrap_inc(granted_q);
          state_d                 = IDLE;
        end
      end
      WRITE_RELAY: begin
        if (!consumer_write_valid[granted_q]) begin
          write_ready_d[granted_q] = 1'b0;
          rr_ptr_d                 = wrap_inc(granted_q);
          state_d                  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      rr_ptr_q            <= '0;
      granted_q           <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      read_data_q         <= '0;
      write_ready_q       <= '0;
      busy_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      granted_q           <= granted_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      read_data_q         <= read_data_d;
      write_ready_q       <= write_ready_d;
      busy_q              <= busy_d;
    end
  end

  assign consumer_read_ready  = read_ready_q;
  assign consumer_read_data   = read_data_q;
  assign consumer_write_ready = write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter; memory model returns addr ^ 8'h4A on reads.
module tb_data_mem_arbiter;

  logic             clk;
  logic             reset;
  logic [7:0]       consumer_read_valid;
  logic [7:0][7:0]  consumer_read_address;
  logic [7:0]       consumer_read_ready;
  logic [7:0][7:0]  consumer_read_data;
  logic [7:0]       consumer_write_valid;
  logic [7:0][7:0]  consumer_write_address;
  logic [7:0][7:0]  consumer_write_data;
  logic [7:0]       consumer_write_ready;
  logic             mem_read_valid;
  logic [7:0]       mem_read_address;
  logic             mem_read_ready;
  logic [7:0]       mem_read_data;
  logic             mem_write_valid;
  logic [7:0]       mem_write_address;
  logic [7:0]       mem_write_data;
  logic             mem_write_ready;
  logic             busy;

  data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .mem_write_valid       (mem_write_valid),
    .mem_write_address     (mem_write_address),
    .mem_write_data        (mem_write_data),
    .mem_write_ready       (mem_write_ready),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] idx;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_mem[$];
  exp_t exp_cons[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   stall_cycles = 0;
  int   scnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: ready one cycle after valid, plus stall_cycles extra cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_read_data   <= 8'h00;
      scnt            <= 0;
    end else begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      if ((mem_read_valid && !mem_read_ready) || (mem_write_valid && !mem_write_ready)) begin
        if (scnt >= stall_cycles) begin
          scnt <= 0;
          if (mem_read_valid) begin
            mem_read_ready <= 1'b1;
            mem_read_data  <= mem_read_address ^ 8'h4A;
          end else begin
            mem_write_ready <= 1'b1;
          end
        end else begin
          scnt <= scnt + 1;
        end
      end else begin
        scnt <= 0;
      end
    end
  end

  task automatic mem_pop(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    if (exp_mem.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_mem_request: wr %0d addr %0h expected none", wr, addr);
    end else begin
      e = exp_mem.pop_front();
      check("mem_kind", {63'd0, wr}, {63'd0, e.wr});
      check("mem_addr", {56'd0, addr}, {56'd0, e.addr});
      if (wr) check("mem_wdata", {56'd0, data}, {56'd0, e.data});
    end
  endtask

  task automatic cons_pop(input logic wr, input logic [7:0] rdy);
    exp_t e;
    int   idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) if (rdy[i]) idx = i;
    if (exp_cons.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_consumer_ready: ready %0h expected none", rdy);
    end else begin
      e = exp_cons.pop_front();
      check("cons_kind", {63'd0, wr}, {63'd0, e.wr});
      check("cons_idx", 64'(idx), {56'd0, e.idx});
      if (!wr) check("cons_rdata", {56'd0, consumer_read_data[idx]}, {56'd0, e.data});
    end
  endtask

  logic       prev_rv, prev_wv;
  logic [7:0] prev_ra, prev_rr, prev_wr;

  // Monitor: pops expectations whenever the DUT presents a new request or completion.
  always @(negedge clk) begin
    if (reset) begin
      check("one_mem_valid", {63'd0, mem_read_valid & mem_write_valid}, 64'd0);
      check("ready_onehot0", {63'd0, $countones({consumer_read_ready, consumer_write_ready}) > 1}, 64'd0);
      check("ready_while_mem_busy",
            {63'd0, (|{consumer_read_ready, consumer_write_ready}) && (mem_read_valid || mem_write_valid)}, 64'd0);
      if (prev_rv && mem_read_valid) check("rd_addr_stable", {56'd0, mem_read_address}, {56'd0, prev_ra});
      if (mem_read_valid && !prev_rv) mem_pop(1'b0, mem_read_address, 8'h00);
      if (mem_write_valid && !prev_wv) mem_pop(1'b1, mem_write_address, mem_write_data);
      if (consumer_read_ready != 0 && prev_rr == 0) cons_pop(1'b0, consumer_read_ready);
      if (consumer_write_ready != 0 && prev_wr == 0) cons_pop(1'b1, consumer_write_ready);
    end
    prev_rv <= mem_read_valid;
    prev_wv <= mem_write_valid;
    prev_ra <= mem_read_address;
    prev_rr <= consumer_read_ready;
    prev_wr <= consumer_write_ready;
  end

  function automatic exp_t mk(input logic wr, input logic [7:0] idx, input logic [7:0] addr,
                              input logic [7:0] data);
    exp_t e;
    e.wr = wr; e.idx = idx; e.addr = addr; e.data = data;
    return e;
  endfunction

  // Wait for the consumer's ready, then drop its valid on the same negedge.
  task automatic wait_done(input int c, input logic wr, input int limit, output int cyc);
    cyc = 0;
    while (!(wr ? consumer_write_ready[c] : consumer_read_ready[c]) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc < limit) n_pass++;
    else $display("FAIL timeout_consumer_%0d: waited %0d cycles, required ready", c, cyc);
    if (wr) consumer_write_valid[c] = 1'b0;
    else    consumer_read_valid[c]  = 1'b0;
  endtask

  initial begin
    int cyc;
    int order [4];
    order = '{5, 0, 3, 5};
    reset = 1'b0;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read_valid", {63'd0, mem_read_valid}, 64'd0);
    check("rst_mem_write_valid", {63'd0, mem_write_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_read_ready", {56'd0, consumer_read_ready}, 64'd0);
    check("rst_read_data", consumer_read_data, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single read: consumer 2, addr 0x10 -> 0x5A
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h10, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd2, 8'h00, 8'h5A));
    consumer_read_address[2] = 8'h10;
    consumer_read_valid[2]   = 1'b1;
    wait_done(2, 1'b0, 20, cyc);
    check("read_latency", 64'(cyc), 64'd3);
    @(negedge clk);
    check("read_ready_cleared", {63'd0, consumer_read_ready[2]}, 64'd0);
    check("busy_after_release", {63'd0, busy}, 64'd0);
    check("read_data_held", {56'd0, consumer_read_data[2]}, 64'h5A);

    // Consumer 3 read moves rr_ptr to 4
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h33, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd3, 8'h00, 8'h79));
    consumer_read_address[3] = 8'h33;
    consumer_read_valid[3]   = 1'b1;
    wait_done(3, 1'b0, 20, cyc);
    @(negedge clk);

    // Round robin from rr_ptr=4 with 0, 3, 5 requesting: 5, 0, 3, 5
    consumer_read_address[0] = 8'h30;
    consumer_read_address[5] = 8'h35;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h35, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd5, 8'h00, 8'h7F));
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h30, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd0, 8'h00, 8'h7A));
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h33, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd3, 8'h00, 8'h79));
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h35, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd5, 8'h00, 8'h7F));
    consumer_read_valid[0] = 1'b1;
    consumer_read_valid[3] = 1'b1;
    consumer_read_valid[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(order[k], 1'b0, 30, cyc);
      if (k == 3) begin
        consumer_read_valid = '0;
      end else begin
        @(negedge clk);
        consumer_read_valid[order[k]] = 1'b1;
      end
    end
    @(negedge clk);

    // Write path: consumer 7 writes 0xC3 to 0xFF
    exp_mem.push_back(mk(1'b1, 8'd0, 8'hFF, 8'hC3));
    exp_cons.push_back(mk(1'b1, 8'd7, 8'h00, 8'h00));
    consumer_write_address[7] = 8'hFF;
    consumer_write_data[7]    = 8'hC3;
    consumer_write_valid[7]   = 1'b1;
    wait_done(7, 1'b1, 20, cyc);
    @(negedge clk);
    check("write_ready_cleared", {56'd0, consumer_write_ready}, 64'd0);

    // rr_ptr wrapped to 0: consumer 0 beats consumer 6
    consumer_read_address[6] = 8'h60;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h30, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd0, 8'h00, 8'h7A));
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h60, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd6, 8'h00, 8'h2A));
    consumer_read_valid[0] = 1'b1;
    consumer_read_valid[6] = 1'b1;
    wait_done(0, 1'b0, 20, cyc);
    wait_done(6, 1'b0, 20, cyc);
    @(negedge clk);

    // Consumer 1 read 0x20 and write 0x21<-0x44 together: read first
    consumer_read_address[1]  = 8'h20;
    consumer_write_address[1] = 8'h21;
    consumer_write_data[1]    = 8'h44;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h20, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd1, 8'h00, 8'h6A));
    exp_mem.push_back(mk(1'b1, 8'd0, 8'h21, 8'h44));
    exp_cons.push_back(mk(1'b1, 8'd1, 8'h00, 8'h00));
    consumer_read_valid[1]  = 1'b1;
    consumer_write_valid[1] = 1'b1;
    wait_done(1, 1'b0, 20, cyc);
    wait_done(1, 1'b1, 20, cyc);
    @(negedge clk);

    // Memory stall of 10 cycles on consumer 4 read 0x40
    stall_cycles = 10;
    consumer_read_address[4] = 8'h40;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h40, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd4, 8'h00, 8'h0A));
    consumer_read_valid[4] = 1'b1;
    wait_done(4, 1'b0, 40, cyc);
    check("stall_latency", 64'(cyc), 64'd13);
    stall_cycles = 0;
    @(negedge clk);

    // Reset during READ_WAIT, then re-grant from consumer 0 upward
    stall_cycles = 20;
    consumer_read_address[2] = 8'h50;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h50, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd2, 8'h00, 8'h1A));
    consumer_read_valid[2] = 1'b1;
    cyc = 0;
    while (!mem_read_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_test_grant", {63'd0, mem_read_valid}, 64'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_mem_read_valid", {63'd0, mem_read_valid}, 64'd0);
    check("async_rst_mem_read_address", {56'd0, mem_read_address}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_read_data", consumer_read_data, 64'd0);
    exp_cons.delete();
    stall_cycles = 0;
    consumer_read_valid[5] = 1'b1;
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h50, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd2, 8'h00, 8'h1A));
    exp_mem.push_back(mk(1'b0, 8'd0, 8'h35, 8'h00));
    exp_cons.push_back(mk(1'b0, 8'd5, 8'h00, 8'h7F));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_done(2, 1'b0, 20, cyc);
    wait_done(5, 1'b0, 20, cyc);
    repeat (3) @(negedge clk);

    check("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
    check("exp_cons_drained", 64'(exp_cons.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
